moldudp64_tx_framer: RTL and testbench

- Transmit-side counterpart of the MoldUDP64 parser.
- Takes a packet command (message count) followed by that many messages, and emits a big-endian MoldUDP64 payload on a 64-bit AXI-stream toward the UDP TX path:
  - header: session (10 B), sequence (8 B), count (2 B);
  - then one block per message: 2-byte length followed by the message data.
- Maintains the downstream sequence number and generates heartbeat and end-of-session packets.

---
 rtl/moldudp64_tx_framer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_moldudp64_tx_framer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_tx_framer.sv
// MoldUDP64 transmit framer: packs header, length fields and message bytes into 64-bit AXI-stream beats.
// Optional idle heartbeat generator is enabled by defining MOLD_TX_HEARTBEAT_EN.
module moldudp64_tx_framer #(
  parameter logic [31:0] HB_CYCLES = 32'd1_000_000,
  parameter int unsigned ACC_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] cfg_session,
  input  logic [63:0] cfg_seq_init,
  input  logic        cfg_seq_load,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [15:0] pkt_count,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic        msg_start,
  input  logic [15:0] msg_len,
  input  logic [63:0] msg_data,
  output logic        udp_axis_tvalid_o,
  input  logic        udp_axis_tready_i,
  output logic [63:0] udp_axis_tdata_o,
  output logic [7:0]  udp_axis_tkeep_o,
  output logic        udp_axis_tlast_o,
  output logic [63:0] next_seq_o,
  output logic        eos_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [5:0] ACC_CAP = 6'(ACC_BYTES);

  state_t       state_q, state_d;
  logic [127:0] acc_q, acc_d;
  logic [4:0]   fill_q, fill_d;
  logic [15:0]  cnt_q, cnt_d, msgs_q, msgs_d, rem_q, rem_d;
  logic         first_q, first_d;
  logic [63:0]  odata_q, odata_d;
  logic [7:0]   okeep_q, okeep_d;
  logic         olast_q, olast_d, ovalid_q, ovalid_d;
  logic [63:0]  seq_q, seq_d;
  logic         eos_q, eos_d;

  logic         take_s, out_free_s, cmd_acc_s, start_s, pop_s, last_s, hb_fire_s;
  logic         room_len_s, room_dat_s, msg_ready_s;
  logic [15:0]  start_cnt_s;
  logic [4:0]   fill_ap_s;
  logic [127:0] acc_ap_s;
  logic [3:0]   push_n_s, chunk_s;
  logic [63:0]  push_data_s, push_mask_s;

`ifdef MOLD_TX_HEARTBEAT_EN
  logic [31:0] idle_q, idle_d;

  assign hb_fire_s = (state_q == S_IDLE) && !eos_q && !pkt_valid && !cfg_seq_load && (idle_q >= HB_CYCLES);

  // Idle-cycle counter: runs only while idle, cleared as soon as a packet starts
  always_comb begin
    if ((state_q == S_IDLE) && !start_s) begin
      idle_d = idle_q + 32'd1;
    end else begin
      idle_d = 32'd0;
    end
  end

  // Idle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= 32'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign hb_fire_s = 1'b0;
`endif

  assign pkt_ready   = (state_q == S_IDLE) && !eos_q && !cfg_seq_load;
  assign cmd_acc_s   = pkt_valid && pkt_ready;
  assign start_s     = cmd_acc_s || hb_fire_s;
  assign start_cnt_s = cmd_acc_s ? pkt_count : 16'd0;

  assign take_s     = ovalid_q && udp_axis_tready_i;
  assign out_free_s = !ovalid_q || take_s;
  // Mid-packet pops keep at least one byte back so the final beat always carries tlast.
  assign pop_s      = (state_q != S_IDLE) && out_free_s && (fill_q > 5'd8);
  assign last_s     = (state_q == S_DRAIN) && out_free_s && (fill_q != 5'd0) && (fill_q <= 5'd8);
  assign fill_ap_s  = pop_s ? (fill_q - 5'd8) : (last_s ? 5'd0 : fill_q);
  assign acc_ap_s   = pop_s ? {acc_q[63:0], 64'd0} : (last_s ? 128'd0 : acc_q);
  assign chunk_s    = (rem_q >= 16'd8) ? 4'd8 : rem_q[3:0];
  assign room_len_s = ({1'b0, fill_ap_s} + 6'd2) <= ACC_CAP;
  assign room_dat_s = ({1'b0, fill_ap_s} + {2'b00, chunk_s}) <= ACC_CAP;

  // Packet sequencing: state transitions, message bookkeeping, sequence/EOS update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    msgs_d      = msgs_q;
    rem_d       = rem_q;
    first_d     = first_q;
    seq_d       = seq_q;
    eos_d       = eos_q;
    push_n_s    = 4'd0;
    push_data_s = 64'd0;
    msg_ready_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_seq_load) begin
          seq_d = cfg_seq_init;
        end else if (start_s) begin
          cnt_d   = start_cnt_s;
          msgs_d  = start_cnt_s;
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if ((cnt_q == 16'd0) || (cnt_q == 16'hFFFF)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (msg_valid && !msg_start) begin
          msg_ready_s = 1'b1;
        end else if (msg_valid && room_len_s) begin
          push_n_s    = 4'd2;
          push_data_s = {msg_len, 48'd0};
          if (msg_len == 16'd0) begin
            msg_ready_s = 1'b1;
            msgs_d      = msgs_q - 16'd1;
            state_d     = (msgs_q == 16'd1) ? S_DRAIN : S_LEN;
          end else begin
            // The start beat stays on the bus; DATA consumes it together with its payload.
            rem_d   = msg_len;
            first_d = 1'b1;
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        msg_ready_s = room_dat_s;
        if (msg_valid && room_dat_s && !(msg_start && !first_q)) begin
          push_n_s    = chunk_s;
          push_data_s = msg_data;
          rem_d       = rem_q - {12'd0, chunk_s};
          first_d     = 1'b0;
          if (rem_q <= 16'd8) begin
            msgs_d  = msgs_q - 16'd1;
            state_d = (msgs_q == 16'd1) ? S_DRAIN : S_LEN;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_DRAIN: begin
        if (take_s && olast_q) begin
          state_d = S_IDLE;
          if (cnt_q == 16'hFFFF) begin
            eos_d = 1'b1;
          end else if (cnt_q != 16'd0) begin
            seq_d = seq_q + {48'd0, cnt_q};
          end else begin
            seq_d = seq_q;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign push_mask_s = {64{1'b1}} << {4'd8 - push_n_s, 3'b000};

  // Accumulator and output register next-state
  always_comb begin
    if (start_s) begin
      acc_d  = {cfg_session[15:0], seq_q, start_cnt_s, 32'd0};
      fill_d = 5'd12;
    end else begin
      acc_d  = acc_ap_s | ({push_data_s & push_mask_s, 64'd0} >> {fill_ap_s, 3'b000});
      fill_d = fill_ap_s + {1'b0, push_n_s};
    end
    odata_d  = odata_q;
    okeep_d  = okeep_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q;
    if (start_s) begin
      odata_d  = cfg_session[79:16];
      okeep_d  = 8'hFF;
      olast_d  = 1'b0;
      ovalid_d = 1'b1;
    end else if (pop_s) begin
      odata_d  = acc_q[127:64];
      okeep_d  = 8'hFF;
      olast_d  = 1'b0;
      ovalid_d = 1'b1;
    end else if (last_s) begin
      odata_d  = acc_q[127:64];
      okeep_d  = 8'hFF << (4'd8 - fill_q[3:0]);
      olast_d  = 1'b1;
      ovalid_d = 1'b1;
    end else if (take_s) begin
      ovalid_d = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
  end

  // State, accumulator, packet context and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 128'd0;
      fill_q   <= 5'd0;
      cnt_q    <= 16'd0;
      msgs_q   <= 16'd0;
      rem_q    <= 16'd0;
      first_q  <= 1'b0;
      odata_q  <= 64'd0;
      okeep_q  <= 8'd0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
      seq_q    <= 64'd1;
      eos_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      msgs_q   <= msgs_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      odata_q  <= odata_d;
      okeep_q  <= okeep_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
      seq_q    <= seq_d;
      eos_q    <= eos_d;
    end
  end

  assign msg_ready         = msg_ready_s;
  assign udp_axis_tvalid_o = ovalid_q;
  assign udp_axis_tdata_o  = odata_q;
  assign udp_axis_tkeep_o  = okeep_q;
  assign udp_axis_tlast_o  = olast_q;
  assign next_seq_o        = seq_q;
  assign eos_o             = eos_q;
  assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_moldudp64_tx_framer.sv
// Self-checking bench for moldudp64_tx_framer: table vectors, randomized packets against a byte-stream model, corner sequences.
module tb_moldudp64_tx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] cfg_session;
  logic [63:0] cfg_seq_init;
  logic        cfg_seq_load;
  logic        pkt_valid, pkt_ready;
  logic [15:0] pkt_count;
  logic        msg_valid, msg_ready, msg_start;
  logic [15:0] msg_len;
  logic [63:0] msg_data;
  logic        udp_axis_tvalid_o, udp_axis_tready_i;
  logic [63:0] udp_axis_tdata_o;
  logic [7:0]  udp_axis_tkeep_o;
  logic        udp_axis_tlast_o;
  logic [63:0] next_seq_o;
  logic        eos_o, busy_o;

  moldudp64_tx_framer dut (
    .clk(clk), .reset(reset),
    .cfg_session(cfg_session), .cfg_seq_init(cfg_seq_init), .cfg_seq_load(cfg_seq_load),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_count(pkt_count),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_start(msg_start),
    .msg_len(msg_len), .msg_data(msg_data),
    .udp_axis_tvalid_o(udp_axis_tvalid_o), .udp_axis_tready_i(udp_axis_tready_i),
    .udp_axis_tdata_o(udp_axis_tdata_o), .udp_axis_tkeep_o(udp_axis_tkeep_o),
    .udp_axis_tlast_o(udp_axis_tlast_o),
    .next_seq_o(next_seq_o), .eos_o(eos_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    int          len0;
    int          len1;
    int          mode;
    int          exp_beats;
    logic [7:0]  exp_keep;
    logic [63:0] seq_inc;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          lens_g[$];
  logic [7:0]  pay_g[$];
  logic [7:0]  got_g[$];
  logic [7:0]  exp_g[$];
  logic [63:0] model_seq;
  localparam logic [79:0] SESS = "SESS000001";

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference payload: header then (length, data) blocks, straight from the message list.
  task automatic build_exp(input logic [15:0] cnt, input logic [79:0] sess);
    int p;
    logic [15:0] l;
    exp_g.delete();
    for (int i = 0; i < 10; i++) exp_g.push_back(sess[79-8*i -: 8]);
    for (int i = 0; i < 8; i++)  exp_g.push_back(model_seq[63-8*i -: 8]);
    exp_g.push_back(cnt[15:8]);
    exp_g.push_back(cnt[7:0]);
    p = 0;
    for (int m = 0; m < lens_g.size(); m++) begin
      l = 16'(lens_g[m]);
      exp_g.push_back(l[15:8]);
      exp_g.push_back(l[7:0]);
      for (int k = 0; k < lens_g[m]; k++) exp_g.push_back(pay_g[p+k]);
      p += lens_g[m];
    end
  endtask

  task automatic drive_cmd(input logic [15:0] cnt, input logic [79:0] sess);
    logic acc;
    cfg_session = sess;
    pkt_count   = cnt;
    pkt_valid   = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = pkt_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    pkt_valid = 1'b0;
  endtask

  task automatic drive_msgs(input int mode);
    int p, len, nb;
    logic acc;
    logic [63:0] d;
    p = 0;
    for (int m = 0; m < lens_g.size(); m++) begin
      len = lens_g[m];
      nb  = (len == 0) ? 1 : (len + 7) / 8;
      for (int b = 0; b < nb; b++) begin
        if (mode == 2) begin
          msg_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        for (int k = 0; k < 8; k++)
          d[63-8*k -: 8] = (b*8 + k < len) ? pay_g[p + b*8 + k] : 8'($urandom);
        msg_data  = d;
        msg_valid = 1'b1;
        msg_start = (b == 0);
        msg_len   = 16'(len);
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          acc = msg_ready;
          @(posedge clk); #1;
          if (acc) break;
        end
      end
      p += len;
    end
    msg_valid = 1'b0;
    msg_start = 1'b0;
  endtask

  task automatic collect(input int mode, output int nb, output logic [7:0] lk);
    logic held, hl, done;
    logic [63:0] hd;
    logic [7:0] hk;
    got_g.delete();
    nb = 0; lk = 8'd0; held = 1'b0; done = 1'b0; hd = 64'd0; hk = 8'd0; hl = 1'b0;
    udp_axis_tready_i = (mode == 2) ? 1'($urandom) : 1'b1;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (held)
        chk("stall_hold", {udp_axis_tvalid_o, udp_axis_tlast_o, udp_axis_tkeep_o, udp_axis_tdata_o}, {1'b1, hl, hk, hd});
      if (udp_axis_tvalid_o && udp_axis_tready_i) begin
        for (int k = 0; k < 8; k++)
          if (udp_axis_tkeep_o[7-k]) got_g.push_back(udp_axis_tdata_o[63-8*k -: 8]);
        nb++;
        lk = udp_axis_tkeep_o;
        if (udp_axis_tlast_o) done = 1'b1;
        else chk("inner_keep", udp_axis_tkeep_o, 8'hFF);
      end
      held = udp_axis_tvalid_o && !udp_axis_tready_i;
      hd = udp_axis_tdata_o; hk = udp_axis_tkeep_o; hl = udp_axis_tlast_o;
      @(posedge clk); #1;
      case (mode)
        1:       udp_axis_tready_i = ~udp_axis_tready_i;
        2:       udp_axis_tready_i = 1'($urandom);
        default: udp_axis_tready_i = 1'b1;
      endcase
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL tlast_timeout: got no tlast in 3000 cycles, expected a terminated packet");
    end
    udp_axis_tready_i = 1'b1;
  endtask

  task automatic run_pkt(input logic [15:0] cnt, input logic [79:0] sess, input int mode,
                         output int nb, output logic [7:0] lk);
    build_exp(cnt, sess);
    fork
      begin drive_cmd(cnt, sess); drive_msgs(mode); end
      begin collect(mode, nb, lk); end
    join
    chk("stream_len", got_g.size(), exp_g.size());
    for (int i = 0; i < exp_g.size(); i++)
      chk($sformatf("stream_byte[%0d]", i), (i < got_g.size()) ? got_g[i] : 8'hxx, exp_g[i]);
    if (cnt != 16'd0 && cnt != 16'hFFFF) model_seq = model_seq + {48'd0, cnt};
    chk("next_seq", next_seq_o, model_seq);
    chk("busy_after", busy_o, 1'b0);
  endtask

  vec_t vt[6];

  initial begin
    int nb, xfer, b;
    logic [7:0] lk;
    logic [63:0] seq_before;
    logic [15:0] rc;
    logic mr, hit;

    vt[0] = '{16'd0, 0, 0, 0, 3, 8'hF0, 64'd0};
    vt[1] = '{16'd2, 3, 9, 0, 5, 8'hF0, 64'd2};
    vt[2] = '{16'd2, 3, 9, 1, 5, 8'hF0, 64'd2};
    vt[3] = '{16'd1, 2, 0, 2, 3, 8'hFF, 64'd1};
    vt[4] = '{16'd1, 8, 0, 0, 4, 8'hFC, 64'd1};
    vt[5] = '{16'd2, 0, 17, 2, 6, 8'h80, 64'd2};

    reset = 1'b1; cfg_session = 80'd0; cfg_seq_init = 64'd0; cfg_seq_load = 1'b0;
    pkt_valid = 1'b0; pkt_count = 16'd0; msg_valid = 1'b0; msg_start = 1'b0;
    msg_len = 16'd0; msg_data = 64'd0; udp_axis_tready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", udp_axis_tvalid_o, 1'b0);
    chk("rst_tdata", udp_axis_tdata_o, 64'd0);
    chk("rst_tkeep_tlast", {udp_axis_tkeep_o, udp_axis_tlast_o}, 9'd0);
    chk("rst_next_seq", next_seq_o, 64'd1);
    chk("rst_eos_busy", {eos_o, busy_o}, 2'b00);
    chk("rst_msg_ready", msg_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_seq = 64'd1;

    for (int v = 0; v < 6; v++) begin
      lens_g.delete(); pay_g.delete();
      if (vt[v].cnt >= 16'd1) begin
        lens_g.push_back(vt[v].len0);
        for (int k = 0; k < vt[v].len0; k++) pay_g.push_back(8'hAA + 8'(8'h11 * k));
      end
      if (vt[v].cnt >= 16'd2) begin
        lens_g.push_back(vt[v].len1);
        for (int k = 0; k < vt[v].len1; k++) pay_g.push_back(8'(k + 1));
      end
      seq_before = next_seq_o;
      run_pkt(vt[v].cnt, SESS, vt[v].mode, nb, lk);
      chk($sformatf("vec%0d_beats", v), nb, vt[v].exp_beats);
      chk($sformatf("vec%0d_last_keep", v), lk, vt[v].exp_keep);
      chk($sformatf("vec%0d_seq", v), next_seq_o, seq_before + vt[v].seq_inc);
      if (v == 1) begin
        chk("len_field0", {got_g[20], got_g[21]}, 16'h0003);
        chk("len_field1", {got_g[25], got_g[26]}, 16'h0009);
      end
    end

    for (int r = 0; r < 12; r++) begin
      lens_g.delete(); pay_g.delete();
      rc = 16'($urandom_range(0, 4));
      for (int m = 0; m < rc; m++) begin
        lens_g.push_back($urandom_range(0, 20));
        for (int k = 0; k < lens_g[m]; k++) pay_g.push_back(8'($urandom));
      end
      run_pkt(rc, {$urandom, $urandom, 16'($urandom)}, $urandom_range(0, 2), nb, lk);
    end

    // Sequence load collides with a command: the load wins, the command waits a cycle.
    cfg_seq_init = 64'h0000_0000_FFFF_FFFF;
    cfg_seq_load = 1'b1;
    pkt_valid = 1'b1; pkt_count = 16'd1;
    @(negedge clk);
    chk("ready_during_load", pkt_ready, 1'b0);
    @(posedge clk); #1;
    cfg_seq_load = 1'b0;
    chk("seq_loaded", next_seq_o, 64'h0000_0000_FFFF_FFFF);
    model_seq = 64'h0000_0000_FFFF_FFFF;
    lens_g.delete(); pay_g.delete();
    lens_g.push_back(0);
    run_pkt(16'd1, SESS, 0, nb, lk);
    chk("hdr_seq_load", {got_g[10], got_g[11], got_g[12], got_g[13], got_g[14], got_g[15], got_g[16], got_g[17]},
        64'h0000_0000_FFFF_FFFF);
    chk("zero_len_field", {got_g[20], got_g[21]}, 16'h0000);
    chk("seq_carry", next_seq_o, 64'h0000_0001_0000_0000);

    // Reset while beat 2 of a 40-byte message packet is on the bus.
    drive_cmd(16'd1, SESS);
    msg_valid = 1'b1; msg_start = 1'b1; msg_len = 16'd40; msg_data = 64'h0102_0304_0506_0708;
    xfer = 0; b = 0; hit = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (udp_axis_tvalid_o && xfer == 2) begin hit = 1'b1; break; end
      if (udp_axis_tvalid_o) xfer++;
      mr = msg_valid && msg_ready;
      @(posedge clk); #1;
      if (mr) begin
        b++;
        msg_start = 1'b0;
        if (b == 5) msg_valid = 1'b0;
      end
    end
    chk("reached_beat2", hit, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_tvalid", udp_axis_tvalid_o, 1'b0);
    chk("abort_tdata", udp_axis_tdata_o, 64'd0);
    chk("abort_tkeep_tlast", {udp_axis_tkeep_o, udp_axis_tlast_o}, 9'd0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_next_seq", next_seq_o, 64'd1);
    msg_valid = 1'b0; msg_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_seq = 64'd1;
    lens_g.delete(); pay_g.delete();
    run_pkt(16'd0, SESS, 0, nb, lk);

    // End of session: header-only packet, then no further command is ever accepted.
    run_pkt(16'hFFFF, SESS, 0, nb, lk);
    chk("eos_beats", nb, 3);
    chk("eos_set", eos_o, 1'b1);
    pkt_valid = 1'b1; pkt_count = 16'd1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("ready_after_eos", pkt_ready, 1'b0);
      @(posedge clk); #1;
    end
    chk("busy_after_eos", busy_o, 1'b0);
    pkt_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
